// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler: FSM state encoding,
// read/write direction constants and the default transaction length limit.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } i2c_state_t;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  localparam int I2C_MAX_LEN_DEF = 4;

endpackage

// File: rtl/i2c_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The last-grant register is updated only when a transaction is recorded as done.
module i2c_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic rec,
  input  logic rec_id,
  output logic any,
  output logic gnt_id
);

  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 1'b1;
    else if (rec) last <= rec_id;
  end

  assign any    = req0 | req1;
  assign gnt_id = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/i2c_txn_sched.sv
// Schedules multi-byte transactions from two requesters onto one byte-level I2C master.
// Optional busy watchdog enabled by defining I2C_SCHED_TIMEOUT_EN.
module i2c_txn_sched
  import i2c_pkg::*;
#(
  parameter int MAX_LEN     = I2C_MAX_LEN_DEF,
  parameter int TIMEOUT_CYC = 12000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [6:0]           req0_addr,
  input  logic                 req0_rw,
  input  logic [2:0]           req0_len,
  input  logic [8*MAX_LEN-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [6:0]           req1_addr,
  input  logic                 req1_rw,
  input  logic [2:0]           req1_len,
  input  logic [8*MAX_LEN-1:0] req1_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [8*MAX_LEN-1:0] rsp_rdata,
  output logic                 rsp_ack_err,
  output logic                 rsp_timeout,
  output logic                 m_enable,
  output logic                 m_rw,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data_wr,
  input  logic                 m_busy,
  input  logic                 m_ack_error,
  input  logic [7:0]           m_data_rd
);

  localparam int W = 8 * MAX_LEN;

  if (MAX_LEN < 1 || MAX_LEN > 7) begin : g_bad_len
    $error("MAX_LEN must be in 1..7");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be positive");
  end

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    if (l == 3'd0) return 3'd1;
    else if (l > 3'(MAX_LEN)) return 3'(MAX_LEN);
    else return l;
  endfunction

  i2c_state_t     state;
  logic [2:0]     k, len;
  logic           cur_id, err, busy_prev, tmo_flag;
  logic [6:0]     lat_addr;
  logic           lat_rw;
  logic [W-1:0]   lat_wdata, rdata;
  logic           arb_any, gnt_id, rise, fall, last_byte, err_now;

  i2c_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .rec    (state == ST_DONE),
    .rec_id (cur_id),
    .any    (arb_any),
    .gnt_id (gnt_id)
  );

  assign rise      = m_busy & ~busy_prev;
  assign fall      = ~m_busy & busy_prev;
  assign last_byte = (k == len - 3'd1);
  assign err_now   = err | m_ack_error;

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign tmo_flag = 1'b0;
`endif

  // control path: FSM, handshakes, master drive and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      k           <= '0;
      len         <= 3'd1;
      cur_id      <= 1'b0;
      err         <= 1'b0;
      busy_prev   <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_ack_err <= 1'b0;
      rsp_timeout <= 1'b0;
      m_enable    <= 1'b0;
      m_rw        <= 1'b0;
      m_addr      <= '0;
      m_data_wr   <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
`endif
    end else begin
      busy_prev  <= m_busy;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      unique case (state)
        ST_IDLE: if (arb_any) begin
          req0_ready <= ~gnt_id;
          req1_ready <= gnt_id;
          cur_id     <= gnt_id;
          len        <= clamp_len(gnt_id ? req1_len : req0_len);
          k          <= '0;
          err        <= 1'b0;
`ifdef I2C_SCHED_TIMEOUT_EN
          tmo_flag   <= 1'b0;
`endif
          state      <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          m_enable  <= 1'b1;
          m_addr    <= lat_addr;
          m_rw      <= lat_rw;
          m_data_wr <= lat_wdata[7:0];
          state     <= ST_WAIT_HI;
        end
        ST_WAIT_HI: if (rise) begin
          // master has taken byte k; queue the next one or let it stop after this
          if (last_byte) m_enable <= 1'b0;
          else m_data_wr <= lat_wdata[8*(int'(k)+1) +: 8];
          state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: if (fall) begin
          err <= err_now;
          k   <= k + 3'd1;
          if (err_now) m_enable <= 1'b0;
          state <= (last_byte || err_now) ? ST_DONE : ST_WAIT_HI;
        end
        ST_DONE: begin
          rsp_valid   <= 1'b1;
          rsp_id      <= cur_id;
          rsp_rdata   <= rdata;
          rsp_ack_err <= err;
          rsp_timeout <= tmo_flag;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef I2C_SCHED_TIMEOUT_EN
      if (state == ST_LAUNCH) tmo_cnt <= '0;
      else if (state == ST_WAIT_HI || state == ST_WAIT_LO) begin
        if (rise || fall) tmo_cnt <= '0;
        else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          m_enable <= 1'b0;
          tmo_flag <= 1'b1;
          state    <= ST_DONE;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end

  // data path: request latch and read-byte capture
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && arb_any) begin
      lat_addr  <= gnt_id ? req1_addr  : req0_addr;
      lat_rw    <= gnt_id ? req1_rw    : req0_rw;
      lat_wdata <= gnt_id ? req1_wdata : req0_wdata;
      rdata     <= '0;
    end else if (state == ST_WAIT_LO && fall && lat_rw == I2C_RD) begin
      rdata[8*int'(k) +: 8] <= m_data_rd;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Scoreboard bench for i2c_txn_sched with a behavioural byte-level I2C master model.
module tb_i2c_txn_sched;

  localparam int MAX_LEN = 4;
  localparam int W = 8 * MAX_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid, req0_ready, req0_rw, req1_valid, req1_ready, req1_rw;
  logic [6:0] req0_addr, req1_addr, m_addr;
  logic [2:0] req0_len, req1_len;
  logic [W-1:0] req0_wdata, req1_wdata, rsp_rdata;
  logic rsp_valid, rsp_id, rsp_ack_err, rsp_timeout;
  logic m_enable, m_rw, m_busy, m_ack_error;
  logic [7:0] m_data_wr, m_data_rd;

  i2c_txn_sched #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_rw(req0_rw), .req0_len(req0_len), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_rw(req1_rw), .req1_len(req1_len), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout),
    .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr), .m_data_wr(m_data_wr),
    .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_rd(m_data_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic id; logic [W-1:0] rdata; logic ack_err; logic tmo;} rsp_t;
  typedef struct packed {logic [6:0] addr; logic rw; logic [7:0] data;} byte_t;

  rsp_t       exp_rsp_q[$];
  byte_t      exp_byte_q[$];
  logic       exp_gnt_q[$];
  logic [7:0] rd_q[$];

  int checks = 0;
  int failures = 0;
  int rsp_seen = 0;
  logic stall = 1'b0;
  logic nack_next = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // I2C master model: one byte per busy pulse while enable is high
  initial begin
    m_busy = 1'b0; m_ack_error = 1'b0; m_data_rd = '0;
    forever begin
      @(negedge clk);
      if (m_enable === 1'b1) begin
        byte_t e;
        logic nk;
        m_busy = 1'b1;
        if (exp_byte_q.size() == 0) fail_now("unexpected_byte");
        else begin
          e = exp_byte_q.pop_front();
          check("m_addr", 64'(m_addr), 64'(e.addr));
          check("m_rw", 64'(m_rw), 64'(e.rw));
          if (!e.rw) check("m_data_wr", 64'(m_data_wr), 64'(e.data));
        end
        if (m_rw) m_data_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
        repeat (4) @(negedge clk);
        while (stall) @(negedge clk);
        nk = nack_next;
        nack_next = 1'b0;
        m_ack_error = nk;
        m_busy = 1'b0;
        @(negedge clk);
        m_ack_error = 1'b0;
        if (nk) check("nack_enable_drop", 64'(m_enable), 64'd0);
      end
    end
  end

  // response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_t e;
        rsp_seen++;
        if (exp_rsp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = exp_rsp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_ack_err", 64'(rsp_ack_err), 64'(e.ack_err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        end
      end
    end
  end

  // grant monitor
  initial begin
    forever begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        if (exp_gnt_q.size() == 0) fail_now("unexpected_grant");
        else check("grant_id", {62'd0, req1_ready, req0_ready},
                   exp_gnt_q.pop_front() ? 64'd2 : 64'd1);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic push_byte(input logic [6:0] a, input logic rw, input logic [7:0] d);
    exp_byte_q.push_back({a, rw, d});
  endtask

  task automatic push_rsp(input logic id, input logic [W-1:0] rd, input logic ae, input logic to);
    exp_rsp_q.push_back({id, rd, ae, to});
  endtask

  task automatic set_req(input logic id, input logic [6:0] a, input logic rw,
                         input logic [2:0] len, input logic [W-1:0] wd);
    if (id) begin
      req1_addr = a; req1_rw = rw; req1_len = len; req1_wdata = wd; req1_valid = 1'b1;
    end else begin
      req0_addr = a; req0_rw = rw; req0_len = len; req0_wdata = wd; req0_valid = 1'b1;
    end
  endtask

  task automatic wait_ready(input logic id);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        return;
      end
    end
    fail_now(id ? "ready1_timeout" : "ready0_timeout");
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic issue(input logic id, input logic [6:0] a, input logic rw,
                       input logic [2:0] len, input logic [W-1:0] wd);
    set_req(id, a, rw, len, wd);
    wait_ready(id);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_rsp_q.size() != 0) fail_now("rsp_drain_timeout");
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int saved;
    req0_valid = 0; req0_addr = 0; req0_rw = 0; req0_len = 0; req0_wdata = '0;
    req1_valid = 0; req1_addr = 0; req1_rw = 0; req1_len = 0; req1_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_master", {47'd0, m_enable, m_rw, m_addr, m_data_wr}, 64'd0);
    check("rst_rsp", {60'd0, rsp_valid, rsp_id, rsp_ack_err, rsp_timeout}, 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // write, two bytes, byte 0 first
    exp_gnt_q.push_back(1'b0);
    push_byte(7'h50, 1'b0, 8'h12);
    push_byte(7'h50, 1'b0, 8'h34);
    push_rsp(1'b0, '0, 1'b0, 1'b0);
    issue(1'b0, 7'h50, 1'b0, 3'd2, W'(16'h3412));
    drain();

    // read, three bytes
    rd_q.push_back(8'hA1); rd_q.push_back(8'hB2); rd_q.push_back(8'hC3);
    exp_gnt_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) push_byte(7'h48, 1'b1, 8'h00);
    push_rsp(1'b1, W'(24'hC3B2A1), 1'b0, 1'b0);
    issue(1'b1, 7'h48, 1'b1, 3'd3, '0);
    drain();

    // simultaneous requests, two rounds
    for (int r = 0; r < 2; r++) begin
      exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1);
      push_byte(7'h10, 1'b0, 8'hA0 + 8'(r));
      push_byte(7'h11, 1'b0, 8'hB0 + 8'(r));
      push_rsp(1'b0, '0, 1'b0, 1'b0);
      push_rsp(1'b1, '0, 1'b0, 1'b0);
      set_req(1'b0, 7'h10, 1'b0, 3'd1, W'(8'hA0 + 8'(r)));
      set_req(1'b1, 7'h11, 1'b0, 3'd1, W'(8'hB0 + 8'(r)));
      fork
        wait_ready(1'b0);
        wait_ready(1'b1);
      join
      drain();
    end

    // NACK on first byte of a three-byte write
    nack_next = 1'b1;
    exp_gnt_q.push_back(1'b0);
    push_byte(7'h3C, 1'b0, 8'h01);
    push_rsp(1'b0, '0, 1'b1, 1'b0);
    issue(1'b0, 7'h3C, 1'b0, 3'd3, W'(24'h030201));
    drain();
    check("rsp_hold_ack_err", 64'(rsp_ack_err), 64'd1);

    // length 0 behaves as 1, length 7 clamps to MAX_LEN
    exp_gnt_q.push_back(1'b0);
    push_byte(7'h05, 1'b0, 8'h77);
    push_rsp(1'b0, '0, 1'b0, 1'b0);
    issue(1'b0, 7'h05, 1'b0, 3'd0, W'(16'h8877));
    drain();
    exp_gnt_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) push_byte(7'h06, 1'b0, 8'h11 * 8'(i + 1));
    push_rsp(1'b0, '0, 1'b0, 1'b0);
    issue(1'b0, 7'h06, 1'b0, 3'd7, W'(32'h44332211));
    drain();

    // master stalls with busy high
    stall = 1'b1;
    exp_gnt_q.push_back(1'b0);
    push_byte(7'h2C, 1'b0, 8'h2A);
    saved = rsp_seen;
`ifdef I2C_SCHED_TIMEOUT_EN
    push_rsp(1'b0, '0, 1'b0, 1'b1);
    issue(1'b0, 7'h2C, 1'b0, 3'd2, W'(16'h2B2A));
    repeat (90) @(negedge clk);
    check("tmo_not_early", 64'(rsp_seen), 64'(saved));
    repeat (60) @(negedge clk);
    check("tmo_rsp_seen", 64'(rsp_seen), 64'(saved + 1));
    check("tmo_enable_low", 64'(m_enable), 64'd0);
    stall = 1'b0;
`else
    issue(1'b0, 7'h2C, 1'b0, 3'd2, W'(16'h2B2A));
    repeat (150) @(negedge clk);
    check("stall_no_rsp", 64'(rsp_seen), 64'(saved));
    check("stall_enable_held", 64'(m_enable), 64'd1);
    push_byte(7'h2C, 1'b0, 8'h2B);
    push_rsp(1'b0, '0, 1'b0, 1'b0);
    stall = 1'b0;
`endif
    drain();

    // reset while waiting for busy to fall
    exp_gnt_q.push_back(1'b0);
    push_byte(7'h31, 1'b0, 8'h55);
    saved = rsp_seen;
    issue(1'b0, 7'h31, 1'b0, 3'd2, W'(16'h6655));
    for (int i = 0; i < 50 && m_busy !== 1'b1; i++) @(negedge clk);
    if (m_busy !== 1'b1) fail_now("busy_wait_timeout");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_enable", 64'(m_enable), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_no_rsp", 64'(rsp_seen), 64'(saved));
    exp_gnt_q.push_back(1'b0);
    push_byte(7'h22, 1'b0, 8'h99);
    push_rsp(1'b0, '0, 1'b0, 1'b0);
    issue(1'b0, 7'h22, 1'b0, 3'd1, W'(8'h99));
    drain();

    check("byte_q_empty", 64'(exp_byte_q.size()), 64'd0);
    check("gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sched.md
I2C_TXN_SCHED -- requirements
Module: i2c_txn_sched

Interface
REQ-001 Parameter MAX_LEN, default 4, max bytes per transaction (1..7).
REQ-002 Parameter TIMEOUT_CYC, default 12000, idle-busy watchdog limit in clk cycles; used only with I2C_SCHED_TIMEOUT_EN.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port clk  in  1  system clock.
REQ-005 Port rst  in  1  asynchronous active-high reset.
REQ-006 Ports reqN_valid  in  1  requester N (N=0,1) has a transaction pending.
REQ-007 Ports reqN_ready  out  1  one-cycle accept pulse to requester N.
REQ-008 Ports reqN_addr  in  7  7-bit slave address.
REQ-009 Ports reqN_rw  in  1  1=read, 0=write.
REQ-010 Ports reqN_len  in  3  byte count, 1..MAX_LEN.
REQ-011 Ports reqN_wdata  in  8*MAX_LEN  write bytes; byte k at [8k+7:8k].
REQ-012 Port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 Port rsp_id  out  1  requester index of completed transaction.
REQ-014 Port rsp_rdata  out  8*MAX_LEN  read bytes, same packing as wdata; zero for writes.
REQ-015 Port rsp_ack_err  out  1  slave NACK seen during transaction.
REQ-016 Port rsp_timeout  out  1  watchdog abort (constant 0 without macro).
REQ-017 Ports m_enable, m_rw  out  1  drive I2C master enable and rw.
REQ-018 Ports m_addr  out  7; m_data_wr  out  8  drive I2C master address and write byte.
REQ-019 Ports m_busy, m_ack_error  in  1; m_data_rd  in  8  I2C master status and read byte.

Function
REQ-020 States: IDLE, LAUNCH, WAIT_HI, WAIT_LO, DONE.
REQ-021 IDLE: if any reqN_valid, grant round-robin (both valid -> the index not granted last); pulse reqN_ready; latch addr/rw/len/wdata; clear byte index k and error flags; go LAUNCH.
REQ-022 LAUNCH: m_enable=1, m_addr/m_rw from latch, m_data_wr=byte 0; go WAIT_HI.
REQ-023 m_busy rising edge (busy & !busy_prev) in WAIT_HI: byte k accepted; if k==len-1 drop m_enable; else present byte k+1 on m_data_wr; go WAIT_LO.
REQ-024 m_busy falling edge in WAIT_LO: if rw, store m_data_rd into rdata byte k; OR m_ack_error into sticky error flag; k<=k+1; if k==len-1 or error go DONE, else go WAIT_HI.
REQ-025 Error at a falling edge: m_enable forced 0 in the same cycle; no further bytes issued.
REQ-026 DONE: one-cycle rsp_valid with rsp_id/rsp_rdata/rsp_ack_err/rsp_timeout; record last grant; go IDLE.
REQ-027 rsp_* data outputs hold until the next rsp_valid.
REQ-028 m_addr/m_rw constant for the whole transaction (no repeated start).
REQ-029 reqN_len of 0 treated as 1; values above MAX_LEN are clamped to MAX_LEN.
REQ-030 A new grant only from IDLE; requests arriving during a transaction wait; at most one transaction in flight.

Reset
REQ-031 Reset: state IDLE, all req*_ready, rsp_*, m_enable, m_rw=0, m_addr=0, m_data_wr=0, busy_prev=0, last grant=1 (req0 wins first tie).
REQ-032 Reset mid-transaction: abort immediately, m_enable=0, no rsp_valid, latched request discarded.

Configuration
REQ-033 With I2C_SCHED_TIMEOUT_EN: counter reloads on every busy edge; in WAIT_HI/WAIT_LO reaching TIMEOUT_CYC forces m_enable=0, rsp_timeout=1, go DONE. Without the macro: no counter, rsp_timeout tied 0.

Structure
REQ-034 Shared package i2c_pkg: state encoding constants, I2C_RD/I2C_WR rw constants, MAX_LEN default.
REQ-035 One sub-module i2c_rr_arb (2-way round-robin grant with last-grant register).

Verification
REQ-036 req0 write addr 0x50 len 2 wdata {0x34,0x12}; model ACKs -> m_data_wr 0x12 then 0x34, rsp_valid id0 ack_err0.
REQ-037 req1 read addr 0x48 len 3, model returns 0xA1,0xB2,0xC3 -> rsp_rdata bytes 0..2 = A1,B2,C3.
REQ-038 req0 and req1 valid same cycle, twice -> grants req0, req1, req0, req1.
REQ-039 Model NACK on first byte of len 3 write -> m_enable low same cycle, rsp_ack_err=1, only 1 byte sent.
REQ-040 Model stalls busy high (macro on, TIMEOUT_CYC=100) -> rsp_timeout=1 after 100 cycles; macro off -> stays WAIT_LO.
REQ-041 Assert rst during WAIT_LO -> m_enable=0 next edge, no rsp_valid, fresh req0 afterwards completes normally.
